// File: rtl/wrr_arbiter_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
// Provides the FSM state enum and the zero-weight clamp.
package wrr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   // A zero weight still earns one beat so no requester starves.
   function automatic logic [31:0] clamp_weight(input logic [31:0] w);
      return (w == 32'd0) ? 32'd1 : w;
   endfunction

endpackage

// File: rtl/wrr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above start_idx, wrapping.
// Ports: req_i, start_idx_i in; found_o, idx_o, onehot_o out.
module rr_pick
   import wrr_arbiter_pkg::*;
#(
   parameter int NumRequests = 8,
   localparam int IdxW = $clog2(NumRequests)
) (
   input  logic [NumRequests-1:0] req_i,
   input  logic [IdxW-1:0]        start_idx_i,
   output logic                   found_o,
   output logic [IdxW-1:0]        idx_o,
   output logic [NumRequests-1:0] onehot_o
);

   always_comb begin
      int pos;
      found_o  = 1'b0;
      idx_o    = '0;
      onehot_o = '0;
      pos      = 0;
      // Walk offsets from farthest to nearest so the nearest hit wins.
      for (int k = NumRequests - 1; k >= 0; k--) begin
         pos = int'(start_idx_i) + k;
         if (pos >= NumRequests) pos = pos - NumRequests;
         if (req_i[pos]) begin
            found_o = 1'b1;
            idx_o   = IdxW'(pos);
         end
      end
      if (found_o) onehot_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter with burst hold and back-to-back switching.
// Ports: clk, rstN, req, weight in; grant, grant_idx, busy out (all registered).
module wrr_arbiter
   import wrr_arbiter_pkg::*;
#(
   parameter int NumRequests = 8,
   parameter int WeightW     = 4,
   localparam int IdxW = $clog2(NumRequests)
) (
   input  logic                           clk,
   input  logic                           rstN,
   input  logic [NumRequests-1:0]         req,
   input  logic [NumRequests*WeightW-1:0] weight,
   output logic [NumRequests-1:0]         grant,
   output logic [IdxW-1:0]                grant_idx,
   output logic                           busy
);

   arb_state_e             state_q, state_d;
   logic [IdxW-1:0]        owner_q, owner_d;
   logic [IdxW-1:0]        ptr_q, ptr_d;
   logic [WeightW-1:0]     cnt_q, cnt_d;
   logic [NumRequests-1:0] grant_q, grant_d;
   logic [IdxW-1:0]        gidx_q, gidx_d;

   logic [IdxW-1:0]        next_owner;
   logic [IdxW-1:0]        start_idx;
   logic                   pick_found;
   logic [IdxW-1:0]        pick_idx;
   logic [NumRequests-1:0] pick_oh;
   logic [WeightW-1:0]     pick_w;
   logic                   beat;
   logic                   rel;

   assign next_owner = (owner_q == IdxW'(NumRequests - 1)) ?
                       '0 : owner_q + 1'b1;

   // One picker serves both cases: from ptr when idle, from owner+1 on release.
   assign start_idx = (state_q == GRANT) ? next_owner : ptr_q;

   rr_pick #(
      .NumRequests(NumRequests)
   ) u_pick (
      .req_i      (req),
      .start_idx_i(start_idx),
      .found_o    (pick_found),
      .idx_o      (pick_idx),
      .onehot_o   (pick_oh)
   );

   always_comb begin
      pick_w = '0;
      for (int i = 0; i < NumRequests; i++) begin
         if (pick_idx == IdxW'(i)) pick_w = weight[i*WeightW +: WeightW];
      end
   end

   assign beat = req[owner_q];
   assign rel  = !beat || (cnt_q == WeightW'(1));

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      unique case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = GRANT;
               owner_d = pick_idx;
               cnt_d   = WeightW'(clamp_weight(32'(pick_w)));
               grant_d = pick_oh;
               gidx_d  = pick_idx;
            end
         end
         GRANT: begin
            if (!rel) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               ptr_d = next_owner;
               if (pick_found) begin
                  owner_d = pick_idx;
                  cnt_d   = WeightW'(clamp_weight(32'(pick_w)));
                  grant_d = pick_oh;
                  gidx_d  = pick_idx;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  grant_d = '0;
                  gidx_d  = '0;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            grant_d = '0;
            gidx_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         state_q <= IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         grant_q <= '0;
         gidx_q  <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
      end
   end

   assign grant     = grant_q;
   assign grant_idx = gidx_q;
   assign busy      = |grant_q;

endmodule

// File: tb/tb_wrr_arbiter.sv
// Directed self-checking bench for wrr_arbiter (N=8, WeightW=4).
// Each scenario task drives stimulus and checks grant/grant_idx/busy inline.
module tb_wrr_arbiter;

   logic        clk;
   logic        rstN;
   logic [7:0]  req;
   logic [31:0] weight;
   logic [7:0]  grant;
   logic [2:0]  grant_idx;
   logic        busy;

   int checks;
   int errors;

   wrr_arbiter #(
      .NumRequests(8),
      .WeightW    (4)
   ) dut (
      .clk      (clk),
      .rstN     (rstN),
      .req      (req),
      .weight   (weight),
      .grant    (grant),
      .grant_idx(grant_idx),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] oh2i(input logic [7:0] oh);
      logic [2:0] r;
      r = 3'd0;
      for (int i = 0; i < 8; i++) if (oh[i]) r = 3'(i);
      return r;
   endfunction

   task automatic do_reset();
      rstN = 1'b0;
      req  = 8'h00;
      step();
      step();
      rstN = 1'b1;
   endtask

   task automatic run_seq(input string name, input logic [7:0] seq[]);
      logic [7:0] eg;
      for (int i = 0; i < seq.size(); i++) begin
         step();
         eg = seq[i];
         checks++;
         if ({grant, grant_idx, busy} !== {eg, oh2i(eg), eg != 8'h00}) begin
            errors++;
            $display("FAIL %s[%0d]: got grant=%h idx=%0d busy=%b want grant=%h idx=%0d busy=%b",
                     name, i, grant, grant_idx, busy, eg, oh2i(eg), eg != 8'h00);
         end
      end
   endtask

   task automatic test_reset();
      weight = 32'h1111_1111;
      rstN   = 1'b0;
      req    = 8'hFF;
      step();
      step();
      checks++;
      if ({grant, grant_idx, busy} !== 12'h000) begin
         errors++;
         $display("FAIL reset: got grant=%h idx=%0d busy=%b want 00/0/0",
                  grant, grant_idx, busy);
      end
      rstN = 1'b1;
      step();
      checks++;
      if ({grant, grant_idx, busy} !== {8'h01, 3'd0, 1'b1}) begin
         errors++;
         $display("FAIL reset_first: got grant=%h idx=%0d busy=%b want 01/0/1",
                  grant, grant_idx, busy);
      end
   endtask

   task automatic test_fair_rotation();
      logic [7:0] s[];
      weight = 32'h1111_1111;
      do_reset();
      req = 8'hFF;
      s = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      run_seq("fair", s);
   endtask

   task automatic test_weighted();
      logic [7:0] s[];
      weight = 32'h1111_1123;
      do_reset();
      req = 8'h03;
      s = '{8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h01, 8'h01, 8'h01, 8'h02, 8'h02};
      run_seq("weighted", s);
   endtask

   task automatic test_sole();
      logic [7:0] s[];
      weight = 32'h1111_1311;
      do_reset();
      req = 8'h04;
      s = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04, 8'h04};
      run_seq("sole", s);
   endtask

   task automatic test_early_drop();
      logic [7:0] s[];
      weight = 32'h1111_1114;
      do_reset();
      req = 8'h03;
      s = '{8'h01, 8'h01, 8'h01};
      run_seq("drop_hold", s);
      req = 8'h02;
      s = '{8'h02, 8'h02};
      run_seq("drop_switch", s);
   endtask

   task automatic test_weight_zero();
      logic [7:0] s[];
      weight = 32'h1101_1111;
      do_reset();
      req = 8'h20;
      s = '{8'h20, 8'h20, 8'h20, 8'h20};
      run_seq("w0_sole", s);
      weight = 32'h1201_1111;
      req = 8'h60;
      s = '{8'h40, 8'h40, 8'h20, 8'h40, 8'h40, 8'h20};
      run_seq("w0_rotate", s);
   endtask

   task automatic test_weight_change();
      logic [7:0] s[];
      weight = 32'h1111_1112;
      do_reset();
      req = 8'h03;
      s = '{8'h01};
      run_seq("wchg_a", s);
      weight = 32'h1111_1114;
      s = '{8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h01, 8'h02};
      run_seq("wchg_b", s);
   endtask

   task automatic test_idle_ptr();
      logic [7:0] s[];
      weight = 32'h1111_1111;
      do_reset();
      req = 8'h01;
      s = '{8'h01};
      run_seq("idle_a", s);
      req = 8'h00;
      s = '{8'h00, 8'h00};
      run_seq("idle_b", s);
      req = 8'h03;
      s = '{8'h02, 8'h01};
      run_seq("idle_ptr", s);
   endtask

   task automatic test_reset_mid_burst();
      logic [7:0] s[];
      weight = 32'h1111_1114;
      do_reset();
      req = 8'hFF;
      s = '{8'h01, 8'h01};
      run_seq("mid_pre", s);
      rstN = 1'b0;
      s = '{8'h00};
      run_seq("mid_rst", s);
      rstN = 1'b1;
      s = '{8'h01};
      run_seq("mid_post", s);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rstN   = 1'b0;
      req    = 8'h00;
      weight = 32'h1111_1111;
      test_reset();
      test_fair_rotation();
      test_weighted();
      test_sole();
      test_early_drop();
      test_weight_zero();
      test_weight_change();
      test_idle_ptr();
      test_reset_mid_burst();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wrr_arbiter.md
# wrr_arbiter

Weighted round-robin arbiter that shares one resource among `NumRequests` requesters, granting each winner a burst of up to `weight[i]` consecutive cycles before rotating. It extends the single-cycle round-robin arbiter in this design with per-requester burst weights, grant hold and back-to-back switching. It sits between the request sources and the shared datapath and drives a registered one-hot grant.

## Interface
- `NumRequests`, default 8: number of requesters (≥2).
- `WeightW`, default 4: width of each per-requester weight field.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rstN`  in  1  reset, synchronous, active-low.
- `req`  in  NumRequests  request vector, bit i = requester i.
- `weight`  in  NumRequests*WeightW  burst length per requester; field i is `weight[i*WeightW +: WeightW]`; quasi-static; value 0 treated as 1.
- `grant`  out  NumRequests  registered one-hot grant, or all-zero.
- `grant_idx`  out  $clog2(NumRequests)  index of the current owner; 0 when idle.
- `busy`  out  1  high while any grant is asserted.

## Operation
- State machine `IDLE` / `GRANT`, plus registers `owner`, `ptr` (round-robin start point) and `cnt` (remaining beats, WeightW bits).
- Pick function: first set bit of `req`, searching upward from a start index with wrap-around modulo NumRequests.
- IDLE: if `req != 0`, pick from `ptr`. Then `owner` = winner, `cnt` = max(weight[winner], 1), grant one-hot, go to GRANT. Otherwise stay in IDLE with grant 0.
- GRANT: each cycle with `req[owner]=1` is one beat.
- Release condition: `req[owner]=0`, or (beat and `cnt==1`).
- No release: on a beat, `cnt` decrements and grant holds. With `req[owner]=0`, the release path is taken instead.
- On release: `ptr` = owner+1 (mod N); pick from owner+1.
  - The current owner is eligible last, and only if still requesting.
  - Winner found: switch grant at the same edge with no idle cycle, and reload `cnt` from the new winner's weight.
  - No winner: go to IDLE, grant 0.
- Sole continuous requester: re-granted indefinitely with no gap. `cnt` reloads every `weight` beats.
- Weight is sampled only when a grant is loaded. Changing `weight` mid-burst does not affect the current burst.
- Requests from non-owners never preempt a burst.
- `grant` is always one-hot or zero. `grant_idx` is consistent with `grant` in the same cycle.

## Timing
- Reset (rstN low at an edge): state IDLE, grant 0, grant_idx 0, busy 0, ptr 0, cnt 0. Reset dominates all other inputs and aborts any burst.
- Request-to-grant latency: `req` sampled at edge k gives `grant` visible after edge k (1 cycle) from IDLE.
- An owner continuously requesting with weight W holds grant for exactly W cycles; the next owner's grant appears at the following edge.
- Owner drops `req` in cycle c: grant is still asserted in cycle c (not counted as a beat). Grant moves or clears at the edge ending cycle c.
- Simultaneous release and new requests are resolved at the same edge; requests arriving in the release cycle are eligible.
- Wrap-around: owner N-1 gives ptr = 0.

## Structure
- Package `wrr_arbiter_pkg`:
  - state enum `arb_state_e {IDLE, GRANT}`;
  - helper function for weight clamping (0→1).
- Sub-module `rr_pick`: combinational; parameter NumRequests; inputs `req` and `start_idx`; outputs `found`, `idx` and one-hot `onehot`. It is used for both the IDLE pick and the release pick.
- Top level holds the FSM, `owner`, `ptr`, `cnt` and the output registers.

## Test plan
Use N=8, WeightW=4 unless stated.
- Reset: rstN low 2 cycles with req=8'hFF → grant=0, busy=0. After rstN high, grant=8'h01 one cycle later.
- Fair rotation: req=8'hFF, all weights 1 → grant sequence 01,02,04,08,10,20,40,80,01, one cycle each, no gaps.
- Weighted: req=8'h03, weight0=3, weight1=2 → grant 01,01,01,02,02,01,01,01,…; grant_idx tracks 0/1.
- Sole requester: req=8'h04 held, weight2=3 → grant=8'h04 continuously, no zero cycle.
- Early drop: weight0=4, req=8'h03; drop req0 after 2 grant cycles → grant 01 for 3 cycles (third cycle with req0 low), then 02.
- Weight 0 / reset mid-burst: weight5=0, req=8'h20 → single-cycle grants re-issued back-to-back. Assert rstN low mid-burst of weight 4 → grant 0 next cycle, and after reset req=8'hFF grants 8'h01 first.
